// File: rtl/divider_32bit_seq.sv
// divider_32bit_seq: iterative restoring divider, one quotient bit per clock.
// Unsigned by default; define DIV_SIGNED_EN to add the is_signed input and
// signed (truncating) division with sign fix-up on the final iteration.
// Also holds subtractor_32bit, the trial subtractor used every iteration.

module subtractor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff
);
  // Modulo-2^32 difference
  assign diff = a - b;
endmodule

// state | meaning
// IDLE  | waiting for start; results hold their last values
// CALC  | one restoring step per clock, cnt counts 31 down to 0
// DONE  | done pulse for one cycle, then back to IDLE
module divider_32bit_seq #(
  parameter logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef DIV_SIGNED_EN
  input  logic        is_signed,
`endif
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [31:0] d_reg;
  logic [31:0] q_reg;
  logic [31:0] r_reg;
  logic [4:0]  cnt;

  logic [32:0] s_shift;
  logic [31:0] trial_diff;
  logic        take;
  logic [31:0] r_next;
  logic [31:0] q_next;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] q_final;
  logic [31:0] r_final;

  // Shifted partial remainder; bit 32 set means it already exceeds any divisor
  assign s_shift = {r_reg, q_reg[31]};

  subtractor_32bit u_sub (
    .a    (s_shift[31:0]),
    .b    (d_reg),
    .diff (trial_diff)
  );

  // Restore-or-keep decision; the modulo diff is exact when s_shift[32] is set
  assign take   = s_shift[32] | (s_shift[31:0] >= d_reg);
  assign r_next = take ? trial_diff : s_shift[31:0];
  assign q_next = {q_reg[30:0], take};

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Operand magnitudes; -2^31 maps onto itself, which is its correct unsigned magnitude
  assign dvd_mag = (is_signed && dividend[31]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[31])  ? -divisor  : divisor;
  assign q_final = neg_q ? -q_next : q_next;
  assign r_final = neg_r ? -r_next : r_next;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_final = q_next;
  assign r_final = r_next;
`endif

  // Sequencing FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == 32'd0) begin
              quotient    <= DIV0_QUOTIENT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              d_reg <= dvs_mag;
              q_reg <= dvd_mag;
              r_reg <= '0;
              cnt   <= 5'd31;
`ifdef DIV_SIGNED_EN
              neg_q <= is_signed & (dividend[31] ^ divisor[31]);
              neg_r <= is_signed & dividend[31];
`endif
              state <= CALC;
            end
          end
        end
        CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            quotient    <= q_final;
            remainder   <= r_final;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32bit_seq.sv
// Directed bench for divider_32bit_seq; signed vectors run when DIV_SIGNED_EN is defined.

module tb_divider_32bit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
`ifdef DIV_SIGNED_EN
  logic        is_signed = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int          n_pass = 0;
  int          n_total = 0;
  int          done_cnt = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  divider_32bit_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat, input bit unsigned_op);
    int          lat;
    int          dc0;
    logic [31:0] prod;
    dc0 = done_cnt;
    launch(a, b);
    check({tag, " busy"}, 32'(busy), 32'd1);
    if (b != 32'd0) begin
      check({tag, " hold_q"}, quotient, last_q);
      check({tag, " hold_r"}, remainder, last_r);
    end
    wait_done(lat);
    check({tag, " latency"}, lat, elat);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    if (!edz) begin
      prod = quotient * b + remainder;
      check({tag, " invariant"}, prod, a);
      if (unsigned_op) check({tag, " rem_lt_div"}, 32'(remainder < b), 32'd1);
    end
    tick();
    check({tag, " done_low"}, 32'(done), 32'd0);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    check({tag, " done_cycles"}, done_cnt - dc0, 32'd1);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int lat;
    int dc0;

    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 1'b1);
    run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 1'b1);
    run_div("max/8..1", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 32, 1'b1);
    run_div("1234/0", 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 0, 1'b1);

    // start while busy must be ignored: result and timing follow the first operation
    launch(32'd50, 32'd5);
    repeat (9) tick();
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wait_done(lat);
    check("ignore latency", lat, 32'd22);
    check("ignore quotient", quotient, 32'd10);
    check("ignore remainder", remainder, 32'd0);
    tick();
    last_q = 32'd10;
    last_r = 32'd0;

    // reset mid-operation: outputs clear at once and no done pulse appears
    dc0 = done_cnt;
    launch(32'd50, 32'd5);
    repeat (9) tick();
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (9) tick();
    check("abort busy", 32'(busy), 32'd1);
    check("abort hold_q", quotient, 32'd10);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort rst busy", 32'(busy), 32'd0);
    check("abort rst done", 32'(done), 32'd0);
    check("abort rst quotient", quotient, 32'd0);
    check("abort rst remainder", remainder, 32'd0);
    check("abort rst div_by_zero", 32'(div_by_zero), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("abort no_done", done_cnt - dc0, 32'd0);
    last_q = 32'd0;
    last_r = 32'd0;
    run_div("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32, 1'b1);

    // back-to-back with the earliest legal second start
    run_div("5/10", 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 32, 1'b1);
    check("b2b held_q", quotient, 32'd0);
    check("b2b held_r", remainder, 32'd5);
    run_div("0/3", 32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 32, 1'b1);

`ifdef DIV_SIGNED_EN
    is_signed = 1'b1;
    run_div("s -7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, 1'b0);
    run_div("s 7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 32, 1'b0);
    run_div("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32, 1'b0);
    run_div("s -5/0", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 0, 1'b0);
    is_signed = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
